// File: rtl/nibble_arb_pkg.sv
// Shared types for the nibble arbiter/serializer: byte/nibble/id typedefs and FSM states.
// Pure declarations, no logic.
// Nibble selection helper keeps every nibble extraction a nibble_t cast.
package nibble_arb_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] byte_t;
    typedef logic [2:0] req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_t;

    // Returns the high nibble when hi is set, else the low nibble (truncating casts).
    function automatic nibble_t nib_sel(input byte_t b, input logic hi);
        nibble_t n;
        if (hi) n = nibble_t'(b >> 4);
        else    n = nibble_t'(b);
        return n;
    endfunction

endpackage

// File: rtl/nibble_arb_serializer_if.sv
// Requester-side and nibble-stream-side signals of the arbiter/serializer.
// master = the serializer itself, slave = the surrounding environment.
// No logic; widths follow NUM_REQ.
interface nibble_arb_serializer_if #(
    parameter int NUM_REQ = 4
);
    import nibble_arb_pkg::*;

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    nibble_t              out_data;
    req_id_t              out_id;
    logic                 out_last;
    logic                 out_ready;
    logic                 busy;

    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, out_last, busy
    );

    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_last, busy
    );

endinterface

// File: rtl/nibble_arb_serializer_rr_pick.sv
// Round-robin pick: first valid index at or after ptr, wrapping at NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_pick
    import nibble_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  req_id_t            i_ptr,
    output logic               o_grant_valid,
    output req_id_t            o_grant_id
);

    localparam logic [3:0] LP_NUM = 4'(NUM_REQ);

    logic [3:0] w_dist;
    logic [3:0] w_best;

    // Pick the valid requester with the smallest wrapped distance from the pointer.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_id    = '0;
        w_dist        = '0;
        w_best        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (4'(i) >= {1'b0, i_ptr}) w_dist = 4'(i) - {1'b0, i_ptr};
            else                         w_dist = 4'(i) + LP_NUM - {1'b0, i_ptr};
            if (i_valid[i] && (!o_grant_valid || (w_dist < w_best))) begin
                o_grant_valid = 1'b1;
                o_grant_id    = req_id_t'(i);
                w_best        = w_dist;
            end
        end
    end

endmodule

// File: rtl/nibble_arb_serializer.sv
// Round-robin arbiter over NUM_REQ byte requesters, emitting each byte as two nibble beats.
// Latency: 1 cycle from grant to first beat; back-to-back bytes at 2 cycles per byte.
// Backpressure: out_ready=0 holds the current beat stable and blocks new grants.
// Optional: define NIBBLE_ARB_ASSERT_EN to compile in protocol assertions.
module nibble_arb_serializer
    import nibble_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int HIGH_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    nibble_arb_serializer_if.master    bus
);

    localparam logic [3:0] LP_NUM = 4'(NUM_REQ);
    localparam logic       LP_HI  = (HIGH_FIRST != 0);

    state_t  r_state;
    state_t  w_state_nxt;
    byte_t   r_byte;
    req_id_t r_id;
    req_id_t r_ptr;

    logic       w_grant_vld;
    req_id_t    w_grant_id;
    req_id_t    w_pick_ptr;
    req_id_t    w_ptr_inc;
    logic [3:0] w_id_p1;
    logic       w_take;
    logic       w_ptr_adv;
    byte_t      w_grant_byte;

    // Pointer after the byte in flight: (grant + 1) mod NUM_REQ.
    always_comb begin
        w_id_p1   = {1'b0, r_id} + 4'd1;
        w_ptr_inc = (w_id_p1 >= LP_NUM) ? '0 : w_id_p1[2:0];
        // A grant in BEAT1 already sees the advanced pointer.
        w_pick_ptr = (r_state == ST_BEAT1) ? w_ptr_inc : r_ptr;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_valid       (bus.req_valid),
        .i_ptr         (w_pick_ptr),
        .o_grant_valid (w_grant_vld),
        .o_grant_id    (w_grant_id)
    );

    // Select the granted requester's byte.
    always_comb begin
        w_grant_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == req_id_t'(i)) w_grant_byte = bus.req_data[8*i +: 8];
        end
    end

    // Next-state and grant decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_ptr_adv   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (bus.out_ready) w_state_nxt = ST_BEAT1;
            end
            ST_BEAT1: begin
                if (bus.out_ready) begin
                    w_ptr_adv = 1'b1;
                    if (w_grant_vld) begin
                        w_take      = 1'b1;
                        w_state_nxt = ST_BEAT0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, captured byte/id and round-robin pointer; reset drops any byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_byte  <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_byte <= w_grant_byte;
                r_id   <= w_grant_id;
            end
            if (w_ptr_adv) r_ptr <= w_ptr_inc;
        end
    end

    // Outputs; everything is forced to zero outside an active beat and during reset.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = w_take && !rst && (w_grant_id == req_id_t'(i));
        end
        bus.busy      = (r_state != ST_IDLE);
        bus.out_valid = (r_state != ST_IDLE);
        bus.out_last  = (r_state == ST_BEAT1);
        bus.out_id    = (r_state != ST_IDLE) ? r_id : '0;
        case (r_state)
            ST_BEAT0: bus.out_data = nib_sel(r_byte, LP_HI);
            ST_BEAT1: bus.out_data = nib_sel(r_byte, !LP_HI);
            default:  bus.out_data = '0;
        endcase
    end

`ifdef NIBBLE_ARB_ASSERT_EN
    // Protocol invariants checked every cycle out of reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(bus.req_ready));
            assert (bus.out_valid == bus.busy);
            assert (!bus.out_last || (r_state == ST_BEAT1));
            assert ((bus.req_ready & ~bus.req_valid) == '0);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_arb_serializer.sv
// Directed bench for nibble_arb_serializer: low-first DUT driven from a vector table,
// plus hand-written sequences for mid-beat reset and a high-first DUT.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_nibble_arb_serializer;
    import nibble_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_arb_serializer_if #(.NUM_REQ(4)) if_lo ();
    nibble_arb_serializer_if #(.NUM_REQ(4)) if_hi ();

    nibble_arb_serializer #(.NUM_REQ(4), .HIGH_FIRST(0)) u_lo (
        .clk (clk),
        .rst (rst),
        .bus (if_lo)
    );

    nibble_arb_serializer #(.NUM_REQ(4), .HIGH_FIRST(1)) u_hi (
        .clk (clk),
        .rst (rst),
        .bus (if_hi)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        rdy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [3:0]  e_od;
        logic [2:0]  e_id;
        logic        e_last;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] vld, input logic [31:0] dat,
                                input logic rdy, input logic [3:0] erdy, input logic eov,
                                input logic [3:0] eod, input logic [2:0] eid, input logic elast);
        vec_t v;
        v.rst = r; v.vld = vld; v.dat = dat; v.rdy = rdy;
        v.e_rdy = erdy; v.e_ov = eov; v.e_od = eod; v.e_id = eid; v.e_last = elast;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_lo(input string tag, input logic [3:0] erdy, input logic eov,
                          input logic [3:0] eod, input logic [2:0] eid, input logic elast);
        chk({tag, " req_ready"}, 32'(if_lo.req_ready), 32'(erdy));
        chk({tag, " out_valid"}, 32'(if_lo.out_valid), 32'(eov));
        chk({tag, " out_data"},  32'(if_lo.out_data),  32'(eod));
        chk({tag, " out_id"},    32'(if_lo.out_id),    32'(eid));
        chk({tag, " out_last"},  32'(if_lo.out_last),  32'(elast));
        chk({tag, " busy"},      32'(if_lo.busy),      32'(eov));
    endtask

    task automatic chk_hi(input string tag, input logic [3:0] erdy, input logic eov,
                          input logic [3:0] eod, input logic [2:0] eid, input logic elast);
        chk({tag, " req_ready"}, 32'(if_hi.req_ready), 32'(erdy));
        chk({tag, " out_valid"}, 32'(if_hi.out_valid), 32'(eov));
        chk({tag, " out_data"},  32'(if_hi.out_data),  32'(eod));
        chk({tag, " out_id"},    32'(if_hi.out_id),    32'(eid));
        chk({tag, " out_last"},  32'(if_hi.out_last),  32'(elast));
        chk({tag, " busy"},      32'(if_hi.busy),      32'(eov));
    endtask

    localparam logic [31:0] D_ONE = 32'h0000_00A5;
    localparam logic [31:0] D_ALL = 32'h4332_2110;
    localparam logic [31:0] D_STL = 32'h007E_0096;

    initial begin
        // Single byte A5 from requester 0: beats 5 then A.
        vecs.push_back(mk(0, 4'b0001, D_ONE, 1, 4'b0001, 0, 4'h0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, D_ONE, 1, 4'b0000, 1, 4'h5, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, D_ONE, 1, 4'b0000, 1, 4'hA, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, D_ONE, 1, 4'b0000, 0, 4'h0, 3'd0, 0));
        // Reset, then all four valid: ids 0,1,2,3,0 back to back, wrap grants 0.
        vecs.push_back(mk(1, 4'b0000, 32'h0, 1, 4'b0000, 0, 4'h0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b1111, D_ALL, 1, 4'b0001, 0, 4'h0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b1111, D_ALL, 1, 4'b0000, 1, 4'h0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b1111, D_ALL, 1, 4'b0010, 1, 4'h1, 3'd0, 1));
        vecs.push_back(mk(0, 4'b1111, D_ALL, 1, 4'b0000, 1, 4'h1, 3'd1, 0));
        vecs.push_back(mk(0, 4'b1111, D_ALL, 1, 4'b0100, 1, 4'h2, 3'd1, 1));
        vecs.push_back(mk(0, 4'b1111, D_ALL, 1, 4'b0000, 1, 4'h2, 3'd2, 0));
        vecs.push_back(mk(0, 4'b1111, D_ALL, 1, 4'b1000, 1, 4'h3, 3'd2, 1));
        vecs.push_back(mk(0, 4'b1111, D_ALL, 1, 4'b0000, 1, 4'h3, 3'd3, 0));
        vecs.push_back(mk(0, 4'b1111, D_ALL, 1, 4'b0001, 1, 4'h4, 3'd3, 1));
        vecs.push_back(mk(0, 4'b0000, D_ALL, 1, 4'b0000, 1, 4'h0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, D_ALL, 1, 4'b0000, 1, 4'h1, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, D_ALL, 1, 4'b0000, 0, 4'h0, 3'd0, 0));
        // Pointer is 1: requester 2 granted, then 5-cycle stall in BEAT0.
        vecs.push_back(mk(0, 4'b0100, D_STL, 1, 4'b0100, 0, 4'h0, 3'd0, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 4'b0101, D_STL, 0, 4'b0000, 1, 4'hE, 3'd2, 0));
        vecs.push_back(mk(0, 4'b0101, D_STL, 1, 4'b0000, 1, 4'hE, 3'd2, 0));
        // Pointer advances to 3, wraps to requester 0.
        vecs.push_back(mk(0, 4'b0101, D_STL, 1, 4'b0001, 1, 4'h7, 3'd2, 1));
        vecs.push_back(mk(0, 4'b0000, D_STL, 1, 4'b0000, 1, 4'h6, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, D_STL, 0, 4'b0000, 1, 4'h9, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, D_STL, 1, 4'b0000, 1, 4'h9, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, D_STL, 1, 4'b0000, 0, 4'h0, 3'd0, 0));
        // Pointer is 1 here; reset must return it to 0 so requester 0 wins over 1.
        vecs.push_back(mk(1, 4'b0011, D_STL, 1, 4'b0000, 0, 4'h0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0011, D_STL, 1, 4'b0001, 0, 4'h0, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, D_STL, 1, 4'b0000, 1, 4'h6, 3'd0, 0));
        vecs.push_back(mk(0, 4'b0000, D_STL, 1, 4'b0000, 1, 4'h9, 3'd0, 1));
        vecs.push_back(mk(0, 4'b0000, D_STL, 1, 4'b0000, 0, 4'h0, 3'd0, 0));

        // Reset state, with requests pending to show req_ready is held low.
        rst = 1'b1;
        if_lo.req_valid = 4'b1111; if_lo.req_data = D_ALL; if_lo.out_ready = 1'b1;
        if_hi.req_valid = 4'b0000; if_hi.req_data = '0;    if_hi.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk_lo("reset", 4'b0000, 0, 4'h0, 3'd0, 0);
        chk_hi("reset_hi", 4'b0000, 0, 4'h0, 3'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            if_lo.req_valid = vecs[i].vld;
            if_lo.req_data  = vecs[i].dat;
            if_lo.out_ready = vecs[i].rdy;
            #1;
            chk_lo($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_od,
                   vecs[i].e_id, vecs[i].e_last);
        end

        // Reset pulsed during BEAT1 of a requester-3 byte while requester 1 waits.
        @(negedge clk);
        if_lo.req_valid = 4'b1000; if_lo.req_data = 32'hD200_5B00; if_lo.out_ready = 1'b1;
        #1; chk_lo("rstmid grant3", 4'b1000, 0, 4'h0, 3'd0, 0);
        @(negedge clk);
        if_lo.req_valid = 4'b0010;
        #1; chk_lo("rstmid beat0", 4'b0000, 1, 4'h2, 3'd3, 0);
        @(negedge clk);
        if_lo.out_ready = 1'b0;
        #1; chk_lo("rstmid beat1", 4'b0000, 1, 4'hD, 3'd3, 1);
        #2 rst = 1'b1;
        #1; chk_lo("rstmid async", 4'b0000, 0, 4'h0, 3'd0, 0);
        @(negedge clk);
        rst = 1'b0; if_lo.out_ready = 1'b1;
        #1; chk_lo("rstmid regrant1", 4'b0010, 0, 4'h0, 3'd0, 0);
        @(negedge clk);
        if_lo.req_valid = 4'b0000;
        #1; chk_lo("rstmid req1 beat0", 4'b0000, 1, 4'hB, 3'd1, 0);
        @(negedge clk);
        #1; chk_lo("rstmid req1 beat1", 4'b0000, 1, 4'h5, 3'd1, 1);
        @(negedge clk);
        #1; chk_lo("rstmid idle", 4'b0000, 0, 4'h0, 3'd0, 0);

        // High nibble first: requester 2 sends 3C.
        @(negedge clk);
        if_hi.req_valid = 4'b0100; if_hi.req_data = 32'h003C_0000;
        #1; chk_hi("hi grant2", 4'b0100, 0, 4'h0, 3'd0, 0);
        @(negedge clk);
        if_hi.req_valid = 4'b0000;
        #1; chk_hi("hi beat0", 4'b0000, 1, 4'h3, 3'd2, 0);
        @(negedge clk);
        #1; chk_hi("hi beat1", 4'b0000, 1, 4'hC, 3'd2, 1);
        @(negedge clk);
        #1; chk_hi("hi idle", 4'b0000, 0, 4'h0, 3'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
